// File: rtl/fpu_wb_pkg.sv
// Shared constants for the FPU writeback / fcsr stage: CSR addresses,
// CSR operation encodings, fflags bit positions and the dynamic rm code.
package fpu_wb_pkg;

    localparam logic [11:0] ADDR_FFLAGS = 12'h001;
    localparam logic [11:0] ADDR_FRM    = 12'h002;
    localparam logic [11:0] ADDR_FCSR   = 12'h003;

    typedef enum logic [1:0] {
        CSR_READ = 2'b00,
        CSR_RW   = 2'b01,
        CSR_RS   = 2'b10,
        CSR_RC   = 2'b11
    } csr_op_e;

    localparam int NV = 4;
    localparam int DZ = 3;
    localparam int OF = 2;
    localparam int UF = 1;
    localparam int NX = 0;

    localparam logic [2:0] RM_DYN = 3'b111;

endpackage

// File: rtl/fpu_wb_fifo.sv
// Small show-ahead FIFO holding integer-destination results until the
// integer writeback accepts them. Head data reads as zero while empty.
module fpu_wb_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 37
) (
    input  logic                     clk,
    input  logic                     rst_l,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count_reg == '0);
    assign full     = (count_reg == CW'(DEPTH));
    assign count    = count_reg;
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign pop_data = empty ? '0 : mem_reg[rd_ptr_reg];

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                mem_reg[wr_ptr_reg] <= push_data;
                wr_ptr_reg          <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            // Pointers wrap naturally because DEPTH is a power of two.
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/fpu_writeback_csr.sv
// Writeback stage behind the single-cycle FPU: aligns results with their
// destinations, buffers integer results, and owns fflags/frm (fcsr).
module fpu_writeback_csr
    import fpu_wb_pkg::*;
#(
    parameter int STD   = 31,
    parameter int DEPTH = 2
) (
    input  logic           clk,
    input  logic           rst_l,
    input  logic           issue_valid,
    input  logic [4:0]     issue_rd,
    input  logic           issue_int_dest,
    input  logic [2:0]     issue_rm,
    output logic [2:0]     fpu_frm,
    output logic           rm_invalid,
    output logic           issue_stall,
    input  logic [STD:0]   FPU_resultant,
    input  logic [31:0]    FPU_Result_rd,
    input  logic [4:0]     S_Flags,
    output logic           fp_wr_en,
    output logic [4:0]     fp_wr_addr,
    output logic [STD:0]   fp_wr_data,
    output logic           int_wb_valid,
    input  logic           int_wb_ready,
    output logic [4:0]     int_wb_rd,
    output logic [31:0]    int_wb_data,
    input  logic           csr_valid,
    input  logic [1:0]     csr_op,
    input  logic [11:0]    csr_addr,
    input  logic [31:0]    csr_wdata,
    output logic           csr_ack,
    output logic [31:0]    csr_rdata,
    output logic           csr_err,
    output logic [4:0]     fflags,
    output logic [2:0]     frm_csr
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic           v1_reg;
    logic [4:0]     rd1_reg;
    logic           int1_reg;
    logic [4:0]     fflags_reg;
    logic [2:0]     frm_reg;
    logic           csr_ack_reg;
    logic [31:0]    csr_rdata_reg;
    logic           csr_err_reg;

    logic           issue_accept;
    logic           int_pending;
    logic [CW-1:0]  fifo_count;
    logic [CW:0]    occupancy;
    logic           fifo_full;
    logic           fifo_empty;
    logic [36:0]    fifo_head;

    logic           addr_ok;
    logic [31:0]    csr_old;
    logic [31:0]    csr_new;
    logic           csr_write;
    logic [4:0]     fflags_next;
    logic [2:0]     frm_next;

    assign int_pending  = v1_reg & int1_reg;
    assign occupancy    = {1'b0, fifo_count} + {{CW{1'b0}}, int_pending};
    // A same-cycle pop is deliberately not credited, keeping the stall simple.
    assign issue_stall  = fifo_full | (occupancy >= (CW+1)'(DEPTH));
    assign issue_accept = issue_valid & ~(issue_int_dest & issue_stall);

    assign fpu_frm    = (issue_rm == RM_DYN) ? frm_reg : issue_rm;
    assign rm_invalid = fpu_frm[2] & (fpu_frm[1] | fpu_frm[0]);

    assign fp_wr_en   = v1_reg & ~int1_reg;
    assign fp_wr_addr = rd1_reg;
    assign fp_wr_data = FPU_resultant;

    fpu_wb_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (37)
    ) u_fifo (
        .clk       (clk),
        .rst_l     (rst_l),
        .push      (int_pending),
        .push_data ({rd1_reg, FPU_Result_rd}),
        .pop       (int_wb_ready),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign int_wb_valid = ~fifo_empty;
    assign int_wb_rd    = fifo_head[36:32];
    assign int_wb_data  = fifo_head[31:0];

    always_comb begin
        addr_ok = 1'b1;
        csr_old = '0;
        case (csr_addr)
            ADDR_FFLAGS: csr_old = {27'b0, fflags_reg};
            ADDR_FRM:    csr_old = {29'b0, frm_reg};
            ADDR_FCSR:   csr_old = {24'b0, frm_reg, fflags_reg};
            default:     addr_ok = 1'b0;
        endcase

        csr_new = csr_old;
        case (csr_op_e'(csr_op))
            CSR_RW:  csr_new = csr_wdata;
            CSR_RS:  csr_new = csr_old | csr_wdata;
            CSR_RC:  csr_new = csr_old & ~csr_wdata;
            default: csr_new = csr_old;
        endcase

        csr_write   = csr_valid & addr_ok & (csr_op_e'(csr_op) != CSR_READ);
        fflags_next = fflags_reg;
        frm_next    = frm_reg;
        if (csr_write) begin
            if (csr_addr == ADDR_FFLAGS) begin
                fflags_next = csr_new[4:0];
            end else if (csr_addr == ADDR_FRM) begin
                frm_next = csr_new[2:0];
            end else begin
                fflags_next = csr_new[4:0];
                frm_next    = csr_new[7:5];
            end
        end
        // Completion flags accumulate on top of any same-cycle CSR write.
        if (v1_reg) begin
            fflags_next = fflags_next | S_Flags;
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            v1_reg        <= 1'b0;
            rd1_reg       <= '0;
            int1_reg      <= 1'b0;
            fflags_reg    <= '0;
            frm_reg       <= '0;
            csr_ack_reg   <= 1'b0;
            csr_rdata_reg <= '0;
            csr_err_reg   <= 1'b0;
        end else begin
            v1_reg <= issue_accept;
            if (issue_accept) begin
                rd1_reg  <= issue_rd;
                int1_reg <= issue_int_dest;
            end
            fflags_reg    <= fflags_next;
            frm_reg       <= frm_next;
            csr_ack_reg   <= csr_valid;
            csr_rdata_reg <= (csr_valid & addr_ok) ? csr_old : '0;
            csr_err_reg   <= csr_valid & ~addr_ok;
        end
    end

    assign csr_ack   = csr_ack_reg;
    assign csr_rdata = csr_rdata_reg;
    assign csr_err   = csr_err_reg;
    assign fflags    = fflags_reg;
    assign frm_csr   = frm_reg;

endmodule

// File: tb/tb_fpu_writeback_csr.sv
// Directed bench for fpu_writeback_csr: stimulus pushes expected responses
// into queues, a negedge monitor pops and compares whenever an output fires.
module tb_fpu_writeback_csr;

    logic        clk = 1'b0;
    logic        rst_l;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        issue_int_dest;
    logic [2:0]  issue_rm;
    logic [2:0]  fpu_frm;
    logic        rm_invalid;
    logic        issue_stall;
    logic [31:0] FPU_resultant;
    logic [31:0] FPU_Result_rd;
    logic [4:0]  S_Flags;
    logic        fp_wr_en;
    logic [4:0]  fp_wr_addr;
    logic [31:0] fp_wr_data;
    logic        int_wb_valid;
    logic        int_wb_ready;
    logic [4:0]  int_wb_rd;
    logic [31:0] int_wb_data;
    logic        csr_valid;
    logic [1:0]  csr_op;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic        csr_ack;
    logic [31:0] csr_rdata;
    logic        csr_err;
    logic [4:0]  fflags;
    logic [2:0]  frm_csr;

    int total = 0;
    int bad   = 0;

    logic [36:0] exp_fp  [$];
    logic [36:0] exp_int [$];
    logic [32:0] exp_csr [$];

    always #5 clk = ~clk;

    fpu_writeback_csr #(.STD(31), .DEPTH(2)) dut (
        .clk            (clk),
        .rst_l          (rst_l),
        .issue_valid    (issue_valid),
        .issue_rd       (issue_rd),
        .issue_int_dest (issue_int_dest),
        .issue_rm       (issue_rm),
        .fpu_frm        (fpu_frm),
        .rm_invalid     (rm_invalid),
        .issue_stall    (issue_stall),
        .FPU_resultant  (FPU_resultant),
        .FPU_Result_rd  (FPU_Result_rd),
        .S_Flags        (S_Flags),
        .fp_wr_en       (fp_wr_en),
        .fp_wr_addr     (fp_wr_addr),
        .fp_wr_data     (fp_wr_data),
        .int_wb_valid   (int_wb_valid),
        .int_wb_ready   (int_wb_ready),
        .int_wb_rd      (int_wb_rd),
        .int_wb_data    (int_wb_data),
        .csr_valid      (csr_valid),
        .csr_op         (csr_op),
        .csr_addr       (csr_addr),
        .csr_wdata      (csr_wdata),
        .csr_ack        (csr_ack),
        .csr_rdata      (csr_rdata),
        .csr_err        (csr_err),
        .fflags         (fflags),
        .frm_csr        (frm_csr)
    );

    task automatic chk(input string name, input logic [36:0] act, input logic [36:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end else begin
            $display("ok   %s value=%h", name, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic csr_req(input logic [1:0] op, input logic [11:0] addr,
                           input logic [31:0] wd, input logic [32:0] exp);
        csr_valid = 1'b1;
        csr_op    = op;
        csr_addr  = addr;
        csr_wdata = wd;
        exp_csr.push_back(exp);
        tick();
        csr_valid = 1'b0;
    endtask

    // Monitor: one comparison per output event against the scoreboard.
    always @(negedge clk) begin
        if (rst_l) begin
            if (fp_wr_en) begin
                if (exp_fp.size() == 0) begin
                    total++; bad++;
                    $display("FAIL fp_unexpected actual=%h required=none", {fp_wr_addr, fp_wr_data});
                end else begin
                    chk("fp_wr", {fp_wr_addr, fp_wr_data}, exp_fp.pop_front());
                end
            end
            if (int_wb_valid && int_wb_ready) begin
                if (exp_int.size() == 0) begin
                    total++; bad++;
                    $display("FAIL int_unexpected actual=%h required=none", {int_wb_rd, int_wb_data});
                end else begin
                    chk("int_wb", {int_wb_rd, int_wb_data}, exp_int.pop_front());
                end
            end
            if (csr_ack) begin
                if (exp_csr.size() == 0) begin
                    total++; bad++;
                    $display("FAIL csr_unexpected actual=%h required=none", {csr_err, csr_rdata});
                end else begin
                    chk("csr_resp", {4'b0, csr_err, csr_rdata}, {4'b0, exp_csr.pop_front()});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst_l = 1'b0; issue_valid = 0; issue_rd = 0; issue_int_dest = 0; issue_rm = 0;
        FPU_resultant = 0; FPU_Result_rd = 0; S_Flags = 0; int_wb_ready = 0;
        csr_valid = 0; csr_op = 0; csr_addr = 0; csr_wdata = 0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_fflags_frm", {fflags, frm_csr}, 0);
        chk("rst_flow", {int_wb_valid, issue_stall, fp_wr_en, csr_ack, csr_err}, 0);
        chk("rst_data", {int_wb_rd, int_wb_data}, 0);
        chk("rst_rdata", csr_rdata, 0);
        rst_l = 1'b1;
        tick();

        // FP destination op
        issue_valid = 1; issue_rd = 5; issue_int_dest = 0;
        exp_fp.push_back({5'd5, 32'h3F80_0000});
        tick();
        issue_valid = 0; FPU_resultant = 32'h3F80_0000; S_Flags = 5'b00001;
        tick();
        S_Flags = 0; FPU_resultant = 0;
        @(negedge clk);
        chk("fp_fflags", fflags, 5'b00001);

        // Backpressure with three int-destination ops
        tick();
        issue_valid = 1; issue_rd = 1; issue_int_dest = 1;
        tick();
        issue_rd = 2; FPU_Result_rd = 32'h11;
        exp_int.push_back({5'd1, 32'h11});
        tick();
        issue_rd = 3; FPU_Result_rd = 32'h22;
        exp_int.push_back({5'd2, 32'h22});
        @(negedge clk);
        chk("stall_rise", issue_stall, 1);
        tick();
        issue_valid = 0; issue_int_dest = 0; FPU_Result_rd = 32'h33;
        @(negedge clk);
        chk("buf_full", {int_wb_valid, issue_stall}, 2'b11);
        chk("buf_head", {int_wb_rd, int_wb_data}, {5'd1, 32'h11});
        tick();
        int_wb_ready = 1;
        repeat (3) tick();
        @(negedge clk);
        chk("drained", {int_wb_valid, issue_stall}, 0);
        chk("drain_queue", exp_int.size(), 0);

        // Dynamic rounding mode
        tick();
        csr_req(2'b01, 12'h002, 32'd3, {1'b0, 32'd0});
        issue_rm = 3'b111;
        @(negedge clk);
        chk("dyn_rm_3", {rm_invalid, fpu_frm}, 4'b0011);
        tick();
        csr_req(2'b01, 12'h002, 32'd5, {1'b0, 32'd3});
        @(negedge clk);
        chk("dyn_rm_5", {rm_invalid, fpu_frm}, 4'b1101);
        tick();
        issue_rm = 3'b110;
        #1 chk("static_rm_6", {rm_invalid, fpu_frm}, 4'b1110);
        issue_rm = 3'b001;
        #1 chk("static_rm_1", {rm_invalid, fpu_frm}, 4'b0001);
        issue_rm = 3'b000;

        // CSR clear racing a completion
        csr_req(2'b01, 12'h001, 32'h10, {1'b0, 32'h1});
        issue_valid = 1; issue_rd = 7; issue_int_dest = 0;
        exp_fp.push_back({5'd7, 32'h4000_0000});
        tick();
        issue_valid = 0; FPU_resultant = 32'h4000_0000; S_Flags = 5'b00100;
        csr_req(2'b11, 12'h001, 32'h1F, {1'b0, 32'h10});
        S_Flags = 0;
        @(negedge clk);
        chk("simul_fflags", fflags, 5'b00100);

        // fcsr view, bad address, set-bits
        tick();
        csr_req(2'b01, 12'h002, 32'd2, {1'b0, 32'd5});
        csr_req(2'b01, 12'h001, 32'd3, {1'b0, 32'd4});
        csr_req(2'b00, 12'h003, 32'hFF, {1'b0, 32'h43});
        csr_req(2'b01, 12'h7C0, 32'hFFFF, {1'b1, 32'h0});
        csr_req(2'b00, 12'h003, 32'h0, {1'b0, 32'h43});
        csr_req(2'b10, 12'h003, 32'h04, {1'b0, 32'h43});
        @(negedge clk);
        chk("rs_fcsr", {fflags, frm_csr}, {5'd7, 3'd2});

        // Reset with two buffered entries
        tick();
        int_wb_ready = 0;
        issue_valid = 1; issue_rd = 9; issue_int_dest = 1;
        tick();
        issue_rd = 10; FPU_Result_rd = 32'h99;
        exp_int.push_back({5'd9, 32'h99});
        tick();
        issue_valid = 0; issue_int_dest = 0; FPU_Result_rd = 32'hAA;
        exp_int.push_back({5'd10, 32'hAA});
        tick();
        @(negedge clk);
        chk("pre_reset_buf", {int_wb_valid, issue_stall, int_wb_rd}, {2'b11, 5'd9});
        #2 rst_l = 1'b0;
        #1;
        chk("async_reset_flow", {int_wb_valid, issue_stall, fp_wr_en}, 0);
        chk("async_reset_csr", {fflags, frm_csr}, 0);
        chk("async_reset_data", {int_wb_rd, int_wb_data}, 0);
        exp_int.delete();
        @(negedge clk);
        rst_l = 1'b1;

        // Normal operation after reset
        tick();
        issue_valid = 1; issue_rd = 3; issue_int_dest = 0;
        exp_fp.push_back({5'd3, 32'h1234_5678});
        tick();
        issue_valid = 0; FPU_resultant = 32'h1234_5678; S_Flags = 5'b00010;
        tick();
        S_Flags = 0;
        @(negedge clk);
        chk("post_reset_fflags", fflags, 5'b00010);
        tick();
        @(negedge clk);
        chk("queues_empty", exp_fp.size() + exp_int.size() + exp_csr.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
